des_key_sched_ctrl: RTL and testbench
=====================================

DES_KEY_SCHED_CTRL -- requirements
Module: des_key_sched_ctrl

Interface
REQ-001 SHALL have parameter OUT_REG, default 1: 1 = registered rd_key (1-cycle read latency); 0 = combinational (same-cycle).
REQ-002 SHALL have clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have key_valid  input  1  key offer.
REQ-005 SHALL have key_ready  output  1  key can be accepted.
REQ-006 SHALL have key_in  input  64 [1:64]  DES key, bit 1 = MSB.
REQ-007 SHALL have decrypt  input  1  read-order mode, sampled with key.
REQ-008 SHALL have sched_busy  output  1  subkey generation in progress.
REQ-009 SHALL have sched_done  output  1  one-cycle pulse when all 16 subkeys are stored.
REQ-010 SHALL have keys_valid  output  1  subkey buffer holds a complete schedule.
REQ-011 SHALL have rd_en, rd_round  input  1, 4  round-engine read request, round 0..15.
REQ-012 SHALL have rd_key, rd_vld  output  48 [1:48], 1  subkey and qualifier.
REQ-013 SHALL have parity_err  output  1  key odd-parity failure, macro-dependent.

Function
REQ-014 SHALL implement FSM IDLE, GEN, READY; key_ready=1 in IDLE and READY only.
REQ-015 Acceptance edge T (key_valid&&key_ready) SHALL load 56-bit CD with PC-1(key_in), capture decrypt, clear keys_valid, clear round counter, and enter GEN.
REQ-016 On each edge T+i (i=1..16), SHALL rotate C and D left by shift[i] (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1) and write PC-2 of the rotated CD to buffer entry i-1.
REQ-017 After edge T+16, SHALL be in READY with keys_valid=1, and sched_done=1 for exactly that cycle; latency = 16 cycles.
REQ-018 sched_busy SHALL equal (state==GEN).
REQ-019 Read: with rd_en=1 and keys_valid=1, SHALL return entry rd_round (decrypt=0) or entry 15-rd_round (decrypt=1), with rd_vld=1, after OUT_REG cycles.
REQ-020 rd_en while keys_valid=0 (IDLE/GEN) SHALL give rd_vld=0 and rd_key=0.
REQ-021 A new key accepted in READY SHALL restart GEN; reads in the cycle of acceptance SHALL use the old schedule; reads after that SHALL return rd_vld=0 until the next sched_done.
REQ-022 key_valid during GEN SHALL be ignored (no acceptance, no state change); the offerer holds it.
REQ-023 Parity bits 8,16,...,64 SHALL NOT affect subkeys.

Reset
REQ-024 With rst=1 at any edge, including mid-GEN, SHALL go to IDLE with key_ready=1 and sched_busy=0, sched_done=0, keys_valid=0, rd_vld=0, rd_key=0, parity_err=0, and round counter=0; buffer contents are don't-care.

Configuration
REQ-025 With DES_KEY_PARITY_CHK_EN defined, SHALL set parity_err at the acceptance edge if any key byte has even parity, hold it until the next acceptance or reset, and still generate the schedule.
REQ-026 Without DES_KEY_PARITY_CHK_EN, parity_err SHALL be constant 0 and no checker logic SHALL exist.

Structure
REQ-027 Package des_pkg SHALL hold PC-1 and PC-2 tables, shift schedule, widths (KEY_W=64, CD_W=56, SUBKEY_W=48, ROUNDS=16), and FSM state typedef.
REQ-028 Sub-module des_subkey_step SHALL be combinational: CD plus shift amount in, rotated CD and PC-2 subkey out; the controller owns all state.

Verification
REQ-029 Key 133457799BBCDFF1, decrypt=0: sched_done 16 cycles after acceptance; rd_round=0 -> 1B02EFFC7072; rd_round=15 -> CB3D8B0E17F5.
REQ-030 Same key, decrypt=1: rd_round=0 -> CB3D8B0E17F5; rd_round=15 -> 1B02EFFC7072.
REQ-031 Key 133457799BBCDFF0 with macro on: parity_err=1, subkeys identical to REQ-029; 133457799BBCDFF1: parity_err=0; macro off: always 0.
REQ-032 rst at cycle T+7: next cycle IDLE, keys_valid=0; read returns rd_vld=0; fresh key -> correct schedule.
REQ-033 key_valid held during GEN: key_ready=0, no restart; second key accepted in READY: keys_valid drops next cycle, new schedule 16 cycles later.
REQ-034 OUT_REG=0 vs 1: rd_key same-cycle vs one cycle after rd_en, with identical values.

Source files
------------

// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 tables, rotation schedule, widths,
// and the controller FSM encoding.
package des_pkg;

   localparam int KEY_W    = 64;
   localparam int CD_W     = 56;
   localparam int HALF_W   = 28;
   localparam int SUBKEY_W = 48;
   localparam int ROUNDS   = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_GEN   = 2'd1;
   localparam state_t ST_READY = 2'd2;

   // Entries are 1-based bit positions, bit 1 = MSB.
   localparam int PC1 [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [SUBKEY_W] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam logic [1:0] SHIFTS [ROUNDS] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   function automatic logic [1:HALF_W] rotl28(
      input logic [1:HALF_W] v,
      input logic [1:0]      n
   );
      case (n)
         2'd1:    return {v[2:HALF_W], v[1]};
         2'd2:    return {v[3:HALF_W], v[1:2]};
         default: return v;
      endcase
   endfunction

endpackage

// File: rtl/des_subkey_step.sv
// One key-schedule step: rotate both CD halves, then compress with PC-2.
// Purely combinational; the controller holds all state.
module des_subkey_step
   import des_pkg::*;
(
   input  logic [1:CD_W]     i_cd,
   input  logic [1:0]        i_shamt,
   output logic [1:CD_W]     o_cd,
   output logic [1:SUBKEY_W] o_subkey
);

   logic [1:CD_W]     w_cd;
   logic [1:SUBKEY_W] w_sub;

   assign w_cd = {rotl28(i_cd[1:HALF_W], i_shamt),
                  rotl28(i_cd[HALF_W+1:CD_W], i_shamt)};

   always_comb begin
      w_sub = '0;
      for (int i = 0; i < SUBKEY_W; i++)
         w_sub[i+1] = w_cd[PC2[i]];
   end

   assign o_cd     = w_cd;
   assign o_subkey = w_sub;

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule controller: PC-1 load, 16-step subkey generation, read port.
// Define DES_KEY_PARITY_CHK_EN to build the odd-parity key checker.
module des_key_sched_ctrl
   import des_pkg::*;
#(
   parameter int OUT_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [1:KEY_W]    key_in,
   input  logic              decrypt,
   output logic              sched_busy,
   output logic              sched_done,
   output logic              keys_valid,
   input  logic              rd_en,
   input  logic [3:0]        rd_round,
   output logic [1:SUBKEY_W] rd_key,
   output logic              rd_vld,
   output logic              parity_err
);

   state_t            r_state;
   logic [1:CD_W]     r_cd;
   logic [3:0]        r_round;
   logic              r_dec;
   logic              r_done;
   logic [1:SUBKEY_W] r_buf [ROUNDS];

   logic [1:CD_W]     w_pc1;
   logic [1:CD_W]     w_cd_nxt;
   logic [1:SUBKEY_W] w_subkey;
   logic              w_accept;
   logic [3:0]        w_idx;
   logic              w_hit;
   logic [1:SUBKEY_W] w_rd_key;

   assign key_ready  = (r_state != ST_GEN);
   assign sched_busy = (r_state == ST_GEN);
   assign keys_valid = (r_state == ST_READY);
   assign sched_done = r_done;
   assign w_accept   = key_valid && key_ready;

   always_comb begin
      w_pc1 = '0;
      for (int i = 0; i < CD_W; i++)
         w_pc1[i+1] = key_in[PC1[i]];
   end

   des_subkey_step u_step (
      .i_cd     (r_cd),
      .i_shamt  (SHIFTS[r_round]),
      .o_cd     (w_cd_nxt),
      .o_subkey (w_subkey)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cd    <= '0;
         r_round <= '0;
         r_dec   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_READY: begin
               if (w_accept) begin
                  r_cd    <= w_pc1;
                  r_dec   <= decrypt;
                  r_round <= '0;
                  r_state <= ST_GEN;
               end
            end
            ST_GEN: begin
               r_cd    <= w_cd_nxt;
               r_round <= r_round + 4'd1;
               if (r_round == 4'd15) begin
                  r_state <= ST_READY;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Subkey store has no reset; keys_valid gates every read.
   always_ff @(posedge clk) begin
      if (r_state == ST_GEN)
         r_buf[r_round] <= w_subkey;
   end

   assign w_idx    = r_dec ? (4'd15 - rd_round) : rd_round;
   assign w_hit    = rd_en && keys_valid;
   assign w_rd_key = w_hit ? r_buf[w_idx] : '0;

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [1:SUBKEY_W] r_rd_key;
         logic              r_rd_vld;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_rd_key <= '0;
               r_rd_vld <= 1'b0;
            end else begin
               r_rd_key <= w_rd_key;
               r_rd_vld <= w_hit;
            end
         end

         assign rd_key = r_rd_key;
         assign rd_vld = r_rd_vld;
      end else begin : g_comb
         assign rd_key = w_rd_key;
         assign rd_vld = w_hit;
      end
   endgenerate

`ifdef DES_KEY_PARITY_CHK_EN
   logic r_parity_err;
   logic w_par_bad;

   // DES keys carry odd parity per byte; any even byte flags the key.
   always_comb begin
      w_par_bad = 1'b0;
      for (int b = 0; b < KEY_W / 8; b++)
         w_par_bad = w_par_bad | ~(^key_in[8*b+1 +: 8]);
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_parity_err <= 1'b0;
      else if (w_accept)
         r_parity_err <= w_par_bad;
   end

   assign parity_err = r_parity_err;
`else
   logic w_unused_par;

   assign w_unused_par = ^{key_in[8],  key_in[16], key_in[24], key_in[32],
                           key_in[40], key_in[48], key_in[56], key_in[64]};
   assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl: registered and combinational
// read-port instances driven in parallel against known DES subkeys.
module tb_des_key_sched_ctrl;

   localparam logic [63:0] K  = 64'h133457799BBCDFF1;
   localparam logic [63:0] KP = 64'h133457799BBCDFF0;
   localparam logic [63:0] KF = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [63:0] K0 = 64'h0101010101010101;

   localparam logic [47:0] S1  = 48'h1B02EFFC7072;
   localparam logic [47:0] S2  = 48'h79AED9DBC9E5;
   localparam logic [47:0] S15 = 48'hBF918D3D3F0A;
   localparam logic [47:0] S16 = 48'hCB3D8B0E17F5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [1:64] key_in = '0;
   logic        decrypt = 1'b0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_round = '0;

   logic        key_ready, sched_busy, sched_done, keys_valid;
   logic [1:48] rd_key;
   logic        rd_vld, parity_err;
   logic        key_ready0, sched_busy0, sched_done0, keys_valid0;
   logic [1:48] rd_key0;
   logic        rd_vld0, parity_err0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   des_key_sched_ctrl #(.OUT_REG(1)) u_dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
      .key_in(key_in), .decrypt(decrypt), .sched_busy(sched_busy),
      .sched_done(sched_done), .keys_valid(keys_valid), .rd_en(rd_en),
      .rd_round(rd_round), .rd_key(rd_key), .rd_vld(rd_vld),
      .parity_err(parity_err)
   );

   des_key_sched_ctrl #(.OUT_REG(0)) u_dut0 (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready0),
      .key_in(key_in), .decrypt(decrypt), .sched_busy(sched_busy0),
      .sched_done(sched_done0), .keys_valid(keys_valid0), .rd_en(rd_en),
      .rd_round(rd_round), .rd_key(rd_key0), .rd_vld(rd_vld0),
      .parity_err(parity_err0)
   );

   typedef struct {
      logic [63:0] key;
      logic        dec;
      logic [3:0]  rnd;
      logic [47:0] exp;
   } vec_t;

   vec_t tbl [11];

   function automatic logic exp_par(input logic [63:0] k);
`ifdef DES_KEY_PARITY_CHK_EN
      logic bad;
      bad = 1'b0;
      for (int b = 0; b < 8; b++)
         if (^k[8*b +: 8] == 1'b0) bad = 1'b1;
      return bad;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (sched_done) begin
            n = c;
            break;
         end
      end
   endtask

   task automatic load(input logic [63:0] k, input logic d);
      int n;
      check("key_ready_before_load", key_ready, 1);
      key_in = k; decrypt = d; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      check("busy_after_accept", sched_busy, 1);
      check("keys_valid_in_gen", keys_valid, 0);
      wait_done(n);
      check("done_latency", n, 16);
      check("keys_valid_ready", keys_valid, 1);
      check("parity_err", parity_err, exp_par(k));
      check("parity_err0", parity_err0, exp_par(k));
   endtask

   task automatic rd(input string nm, input logic [3:0] r, input logic v,
                     input logic [47:0] e);
      rd_en = 1'b1; rd_round = r; #1;
      check({nm, "_vld_comb"}, rd_vld0, v);
      check({nm, "_key_comb"}, rd_key0, e);
      @(posedge clk); #1;
      check({nm, "_vld_reg"}, rd_vld, v);
      check({nm, "_key_reg"}, rd_key, e);
      rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] cur_k;
      logic        cur_d;
      int          n;

      tbl[0]  = '{K,  1'b0, 4'd0,  S1};
      tbl[1]  = '{K,  1'b0, 4'd1,  S2};
      tbl[2]  = '{K,  1'b0, 4'd14, S15};
      tbl[3]  = '{K,  1'b0, 4'd15, S16};
      tbl[4]  = '{K,  1'b1, 4'd0,  S16};
      tbl[5]  = '{K,  1'b1, 4'd1,  S15};
      tbl[6]  = '{K,  1'b1, 4'd15, S1};
      tbl[7]  = '{KP, 1'b0, 4'd0,  S1};
      tbl[8]  = '{KP, 1'b0, 4'd15, S16};
      tbl[9]  = '{KF, 1'b0, 4'd7,  48'hFFFFFFFFFFFF};
      tbl[10] = '{K0, 1'b1, 4'd3,  48'h000000000000};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_key_ready", key_ready, 1);
      check("rst_busy", sched_busy, 0);
      check("rst_done", sched_done, 0);
      check("rst_keys_valid", keys_valid, 0);
      check("rst_rd_vld", rd_vld, 0);
      check("rst_rd_key", rd_key, 0);
      check("rst_parity", parity_err, 0);

      rd("rd_idle", 4'd0, 1'b0, 48'h0);

      cur_k = '0; cur_d = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i == 0 || tbl[i].key != cur_k || tbl[i].dec != cur_d) begin
            load(tbl[i].key, tbl[i].dec);
            cur_k = tbl[i].key;
            cur_d = tbl[i].dec;
         end
         rd($sformatf("vec%0d", i), tbl[i].rnd, 1'b1, tbl[i].exp);
      end

      // Reset in the middle of generation.
      key_in = KP; decrypt = 1'b0; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      check("mid_par_set", parity_err, exp_par(KP));
      rd("rd_gen", 4'd0, 1'b0, 48'h0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_busy", sched_busy, 0);
      check("mid_rst_keys_valid", keys_valid, 0);
      check("mid_rst_key_ready", key_ready, 1);
      check("mid_rst_done", sched_done, 0);
      check("mid_rst_parity", parity_err, 0);
      rd("rd_after_rst", 4'd0, 1'b0, 48'h0);
      load(K, 1'b0);
      rd("fresh_r0", 4'd0, 1'b1, S1);

      // Key held during generation, then accepted in READY.
      key_in = K; decrypt = 1'b0; key_valid = 1'b1;
      @(posedge clk); #1;
      key_in = KF;
      check("hold_key_ready", key_ready, 0);
      repeat (4) @(posedge clk);
      #1;
      check("hold_busy", sched_busy, 1);
      wait_done(n);
      check("hold_no_restart", n, 12);
      check("done_cycle_ready", key_ready, 1);
      rd_en = 1'b1; rd_round = 4'd0; #1;
      check("acc_cycle_comb", rd_key0, S1);
      @(posedge clk); #1;
      key_valid = 1'b0;
      check("acc_cycle_vld", rd_vld, 1);
      check("acc_cycle_key", rd_key, S1);
      check("done_one_cycle", sched_done, 0);
      check("second_keys_valid", keys_valid, 0);
      check("second_busy", sched_busy, 1);
      check("after_acc_comb", rd_vld0, 0);
      @(posedge clk); #1;
      rd_en = 1'b0;
      check("after_acc_reg", rd_vld, 0);
      wait_done(n);
      check("second_latency", n, 15);
      rd("second_r5", 4'd5, 1'b1, 48'hFFFFFFFFFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
